timer_countdown_ctrl: RTL and testbench
=======================================

// Module: timer_countdown_ctrl
// PURPOSE
//  Parametrised countdown timer for the motor PWM timer mode. Divides the tick clock into seconds,
//  counts a loaded preset down to zero, and supports pause/resume, reload and off-button abort.
//  Flags expiry so the motor FSM can stop the PWM. Widths and tick rate are parameters.
//  Sits between the mode/button FSM and the motor PWM FSM.
// PARAMETERS
//  CLK_PER_SEC  1000  i_clk cycles per second, >=2 (1 kHz tick clock in the current build)
//  SEC_W        5     width of preset/remaining/elapsed second counts
// PORTS
//  i_clk        in   1      system tick clock
//  i_reset      in   1      synchronous, active-high reset
//  i_timer_mode in   1      timer mode enable; low forces IDLE and clears all counts
//  i_offButton  in   1      synchronous abort (level): forces IDLE, clears counts
//  i_load       in   1      single-cycle pulse: latch i_timeState and start the countdown
//  i_pause      in   1      level: hold the countdown while high (RUN<->PAUSE)
//  i_timeState  in   SEC_W  preset duration in seconds, sampled only on i_load
//  o_remaining  out  SEC_W  seconds left
//  o_elapsed    out  SEC_W  seconds elapsed since load
//  o_running    out  1      high in RUN only
//  o_done       out  1      high in DONE (level)
//  o_expired    out  1      one-cycle pulse on the cycle DONE is entered
// BEHAVIOUR
//  - Reset: state=IDLE, prescaler=0, o_remaining=0, o_elapsed=0, o_running=0, o_done=0, o_expired=0.
//  - Per-edge priority: i_reset > i_offButton > !i_timer_mode > i_load > i_pause > second tick.
//  - Off-button or !i_timer_mode in any state -> IDLE with the reset values above.
//  - States: IDLE, RUN, PAUSE, DONE; all outputs registered.
//  - i_load with i_timeState!=0 in any state -> RUN next cycle: remaining=i_timeState, elapsed=0,
//    prescaler=0, o_done=0. Load overrides a simultaneous pause. Reload mid-run restarts cleanly.
//  - i_load with i_timeState==0 -> IDLE with counts cleared. No o_expired pulse is generated.
//  - RUN: prescaler increments each cycle. At prescaler==CLK_PER_SEC-1 it wraps to 0,
//    remaining decrements and elapsed increments on the same edge.
//  - First decrement lands CLK_PER_SEC cycles after the load edge.
//    Total RUN time = preset*CLK_PER_SEC cycles.
//  - Wrap edge with remaining==1: remaining->0, state->DONE, o_expired=1 for exactly one cycle.
//  - RUN & i_pause -> PAUSE. Prescaler and counts are frozen (fraction of second preserved).
//  - PAUSE & !i_pause -> RUN, resuming from the frozen prescaler value.
//  - i_pause in IDLE/DONE is ignored.
//  - DONE holds remaining=0 and elapsed=preset until load, off-button or mode exit.
//  - Counters never wrap. elapsed<=preset<=2^SEC_W-1 by construction.
//  - Prescaler width = $clog2(CLK_PER_SEC), unsigned compare.
// STRUCTURE
//  - Shared package (timer_pkg): state localparams ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE
//    (2-bit), default CLK_PER_SEC.
//  - Sub-module sec_tick_gen #(CLK_PER_SEC): inputs clear/hold, output 1-cycle tick at wrap.
//    Cleared on load/IDLE/DONE, held in PAUSE.
//  - Top module: FSM plus remaining/elapsed registers and the expiry pulse register.
// TESTING  (bench uses CLK_PER_SEC=4, SEC_W=5)
//  - Load 3, no pause -> remaining 3,2,1,0 at load+4/8/12 cycles;
//    o_expired single pulse at load+12; o_done held; elapsed=3.
//  - Load 5, pause at cycle 6 for 10 cycles -> remaining frozen at 4.
//    Reaches 0 at load+20+10; fraction preserved.
//  - Load 5, offButton at cycle 9 -> next cycle IDLE, remaining=0, elapsed=0; no o_expired.
//  - Load 4, reload 2 at cycle 7 -> remaining=2, elapsed=0; expiry at reload+8 cycles.
//  - Load 0 -> stays IDLE, no o_expired. Drop i_timer_mode in RUN -> IDLE, counts cleared.
//  - i_reset asserted mid-RUN with simultaneous i_load -> reset wins; all outputs 0 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and default tick rate.
// Encodings are plain 2-bit constants so legacy code and bound checkers can compare them directly.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_CLK_PER_SEC = 1000;
  localparam int DEF_SEC_W       = 5;

  // RUN and PAUSE both own a live countdown whose fraction of a second must survive.
  function automatic logic is_counting(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/timer_countdown_if.sv
// Control/status bundle between the mode/button FSM (master) and the countdown timer (slave).
// Signalling: i_load is a one-cycle pulse that samples i_timeState on that edge; i_offButton,
// i_timer_mode and i_pause are levels; o_expired is a one-cycle pulse, all other outputs are levels.
interface timer_countdown_if #(
  parameter int SEC_W = 5
) ();

  logic             i_timer_mode;
  logic             i_offButton;
  logic             i_load;
  logic             i_pause;
  logic [SEC_W-1:0] i_timeState;
  logic [SEC_W-1:0] o_remaining;
  logic [SEC_W-1:0] o_elapsed;
  logic             o_running;
  logic             o_done;
  logic             o_expired;

  modport master (
    output i_timer_mode, i_offButton, i_load, i_pause, i_timeState,
    input  o_remaining, o_elapsed, o_running, o_done, o_expired
  );

  modport slave (
    input  i_timer_mode, i_offButton, i_load, i_pause, i_timeState,
    output o_remaining, o_elapsed, o_running, o_done, o_expired
  );

endinterface

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: counts clock cycles and emits a one-cycle tick on the wrap edge.
// Clear forces the count to zero; hold freezes it so a paused fraction of a second is kept.
module sec_tick_gen #(
  parameter int CLK_PER_SEC = timer_pkg::DEF_CLK_PER_SEC
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);

  localparam int            PW   = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          wrap;

  assign wrap   = (presc_q == PMAX);
  assign o_tick = !i_clear && !i_hold && wrap;

  always_comb begin
    presc_d = presc_q;
    if (i_clear) begin
      presc_d = '0;
    end else if (!i_hold) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_countdown_ctrl.sv
// Countdown timer for the motor PWM timer mode: loads a preset in seconds, counts it down,
// supports pause/resume, reload and abort, and flags expiry to the motor FSM.
module timer_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int SEC_W       = DEF_SEC_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  timer_countdown_if.slave   bus,
  output logic [1:0]         o_state
);

  logic [1:0]       state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [SEC_W-1:0] el_q, el_d;
  logic             running_q, done_q;
  logic             expired_q, expired_d;
  logic             abort;
  logic             tick_clear;
  logic             tick;

  assign abort = bus.i_offButton || !bus.i_timer_mode;

  // The prescaler restarts on any load and is parked at zero outside a live countdown.
  // Holding on the pause level means the resume edge itself already counts.
  assign tick_clear = abort || bus.i_load || !is_counting(state_q);

  sec_tick_gen #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_sec_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (tick_clear),
    .i_hold  (bus.i_pause),
    .o_tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    el_d      = el_q;
    expired_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      el_d    = '0;
    end else if (bus.i_load) begin
      el_d = '0;
      if (bus.i_timeState != '0) begin
        state_d = ST_RUN;
        rem_d   = bus.i_timeState;
      end else begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    end else if (is_counting(state_q)) begin
      if (bus.i_pause) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
        if (tick && (rem_q != '0)) begin
          rem_d = rem_q - SEC_W'(1);
          el_d  = el_q + SEC_W'(1);
          if (rem_q == SEC_W'(1)) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      el_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      el_q      <= el_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      expired_q <= expired_d;
    end
  end

  assign bus.o_remaining = rem_q;
  assign bus.o_elapsed   = el_q;
  assign bus.o_running   = running_q;
  assign bus.o_done      = done_q;
  assign bus.o_expired   = expired_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// Directed bench for timer_countdown_ctrl with CLK_PER_SEC=4, SEC_W=5.
module tb_timer_countdown_ctrl;

  localparam int CPS = 4;
  localparam int SW  = 5;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dut_state;
  int         tests_run = 0;
  int         fails     = 0;
  int         exp_cnt   = 0;

  timer_countdown_if #(.SEC_W(SW)) bus ();

  timer_countdown_ctrl #(
    .CLK_PER_SEC (CPS),
    .SEC_W       (SW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_state (dut_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_expired === 1'b1) exp_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [SW-1:0] v);
    bus.i_load      = 1'b1;
    bus.i_timeState = v;
    step(1);
    bus.i_load      = 1'b0;
  endtask

  task automatic go_idle();
    bus.i_offButton = 1'b1;
    step(1);
    bus.i_offButton = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_timer_mode = 1'b1;
    bus.i_offButton  = 1'b0;
    bus.i_load       = 1'b0;
    bus.i_pause      = 1'b0;
    bus.i_timeState  = '0;
    step(3);
    rst = 1'b0;
    tests_run++; if (dut_state !== S_IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", dut_state, S_IDLE); end
    tests_run++; if ({bus.o_remaining, bus.o_elapsed} !== 10'd0) begin fails++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.o_remaining, bus.o_elapsed); end
    tests_run++; if ({bus.o_running, bus.o_done, bus.o_expired} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {bus.o_running, bus.o_done, bus.o_expired}); end
    exp_cnt = 0;
  endtask

  task automatic test_countdown();
    do_load(5'd3);
    tests_run++; if (bus.o_remaining !== 5'd3 || bus.o_running !== 1'b1) begin fails++; $display("FAIL cd_load got rem=%0d run=%b exp rem=3 run=1", bus.o_remaining, bus.o_running); end
    step(3);
    tests_run++; if (bus.o_remaining !== 5'd3) begin fails++; $display("FAIL cd_e3 got=%0d exp=3", bus.o_remaining); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd2 || bus.o_elapsed !== 5'd1) begin fails++; $display("FAIL cd_e4 got=%0d/%0d exp=2/1", bus.o_remaining, bus.o_elapsed); end
    step(4);
    tests_run++; if (bus.o_remaining !== 5'd1) begin fails++; $display("FAIL cd_e8 got=%0d exp=1", bus.o_remaining); end
    step(3);
    tests_run++; if (bus.o_remaining !== 5'd1 || bus.o_expired !== 1'b0) begin fails++; $display("FAIL cd_e11 got rem=%0d exp_pulse=%b exp rem=1 pulse=0", bus.o_remaining, bus.o_expired); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd0 || bus.o_expired !== 1'b1 || bus.o_done !== 1'b1 || bus.o_running !== 1'b0) begin fails++; $display("FAIL cd_e12 got rem=%0d exp=%b done=%b run=%b exp 0/1/1/0", bus.o_remaining, bus.o_expired, bus.o_done, bus.o_running); end
    tests_run++; if (bus.o_elapsed !== 5'd3) begin fails++; $display("FAIL cd_elapsed got=%0d exp=3", bus.o_elapsed); end
    step(1);
    tests_run++; if (bus.o_expired !== 1'b0 || bus.o_done !== 1'b1 || dut_state !== S_DONE) begin fails++; $display("FAIL cd_e13 got exp=%b done=%b st=%0d exp 0/1/%0d", bus.o_expired, bus.o_done, dut_state, S_DONE); end
    bus.i_pause = 1'b1;
    step(3);
    bus.i_pause = 1'b0;
    tests_run++; if (dut_state !== S_DONE || bus.o_remaining !== 5'd0 || bus.o_elapsed !== 5'd3) begin fails++; $display("FAIL cd_pause_in_done got st=%0d rem=%0d el=%0d exp %0d/0/3", dut_state, bus.o_remaining, bus.o_elapsed, S_DONE); end
    tests_run++; if (exp_cnt !== 1) begin fails++; $display("FAIL cd_pulse_count got=%0d exp=1", exp_cnt); end
    go_idle();
  endtask

  task automatic test_pause();
    do_load(5'd5);
    step(5);
    tests_run++; if (bus.o_remaining !== 5'd4) begin fails++; $display("FAIL pz_e5 got=%0d exp=4", bus.o_remaining); end
    bus.i_pause = 1'b1;
    step(1);
    tests_run++; if (dut_state !== S_PAUSE || bus.o_running !== 1'b0) begin fails++; $display("FAIL pz_enter got st=%0d run=%b exp %0d/0", dut_state, bus.o_running, S_PAUSE); end
    step(9);
    tests_run++; if (bus.o_remaining !== 5'd4 || bus.o_elapsed !== 5'd1) begin fails++; $display("FAIL pz_frozen got=%0d/%0d exp=4/1", bus.o_remaining, bus.o_elapsed); end
    bus.i_pause = 1'b0;
    step(1);
    tests_run++; if (dut_state !== S_RUN) begin fails++; $display("FAIL pz_resume got=%0d exp=%0d", dut_state, S_RUN); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd4) begin fails++; $display("FAIL pz_e17 got=%0d exp=4", bus.o_remaining); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd3) begin fails++; $display("FAIL pz_fraction_e18 got=%0d exp=3", bus.o_remaining); end
    step(11);
    tests_run++; if (bus.o_remaining !== 5'd1 || bus.o_done !== 1'b0) begin fails++; $display("FAIL pz_e29 got rem=%0d done=%b exp 1/0", bus.o_remaining, bus.o_done); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd0 || bus.o_expired !== 1'b1 || bus.o_elapsed !== 5'd5) begin fails++; $display("FAIL pz_e30 got rem=%0d exp=%b el=%0d exp 0/1/5", bus.o_remaining, bus.o_expired, bus.o_elapsed); end
    go_idle();
  endtask

  task automatic test_off_button();
    do_load(5'd5);
    step(8);
    tests_run++; if (bus.o_remaining !== 5'd3) begin fails++; $display("FAIL off_e8 got=%0d exp=3", bus.o_remaining); end
    bus.i_offButton = 1'b1;
    step(1);
    bus.i_offButton = 1'b0;
    tests_run++; if (dut_state !== S_IDLE || bus.o_remaining !== 5'd0 || bus.o_elapsed !== 5'd0 || bus.o_running !== 1'b0) begin fails++; $display("FAIL off_e9 got st=%0d rem=%0d el=%0d run=%b exp 0/0/0/0", dut_state, bus.o_remaining, bus.o_elapsed, bus.o_running); end
    step(10);
    tests_run++; if (exp_cnt !== 0 || dut_state !== S_IDLE) begin fails++; $display("FAIL off_no_expiry got pulses=%0d st=%0d exp 0/0", exp_cnt, dut_state); end
    exp_cnt = 0;
  endtask

  task automatic test_reload();
    do_load(5'd4);
    step(6);
    tests_run++; if (bus.o_remaining !== 5'd3) begin fails++; $display("FAIL rl_e6 got=%0d exp=3", bus.o_remaining); end
    do_load(5'd2);
    tests_run++; if (bus.o_remaining !== 5'd2 || bus.o_elapsed !== 5'd0 || dut_state !== S_RUN) begin fails++; $display("FAIL rl_restart got rem=%0d el=%0d st=%0d exp 2/0/1", bus.o_remaining, bus.o_elapsed, dut_state); end
    step(7);
    tests_run++; if (bus.o_remaining !== 5'd1 || bus.o_elapsed !== 5'd1 || bus.o_expired !== 1'b0) begin fails++; $display("FAIL rl_plus7 got rem=%0d el=%0d exp=%b exp 1/1/0", bus.o_remaining, bus.o_elapsed, bus.o_expired); end
    step(1);
    tests_run++; if (bus.o_remaining !== 5'd0 || bus.o_expired !== 1'b1 || bus.o_elapsed !== 5'd2) begin fails++; $display("FAIL rl_plus8 got rem=%0d exp=%b el=%0d exp 0/1/2", bus.o_remaining, bus.o_expired, bus.o_elapsed); end
    go_idle();
  endtask

  task automatic test_zero_load_and_mode();
    do_load(5'd0);
    step(2);
    tests_run++; if (dut_state !== S_IDLE || bus.o_remaining !== 5'd0 || exp_cnt !== 0) begin fails++; $display("FAIL zero_load got st=%0d rem=%0d pulses=%0d exp 0/0/0", dut_state, bus.o_remaining, exp_cnt); end
    do_load(5'd6);
    step(2);
    do_load(5'd0);
    tests_run++; if (dut_state !== S_IDLE || bus.o_remaining !== 5'd0 || bus.o_elapsed !== 5'd0) begin fails++; $display("FAIL zero_load_run got st=%0d rem=%0d el=%0d exp 0/0/0", dut_state, bus.o_remaining, bus.o_elapsed); end
    do_load(5'd3);
    step(5);
    tests_run++; if (bus.o_remaining !== 5'd2 || bus.o_elapsed !== 5'd1) begin fails++; $display("FAIL mode_pre got=%0d/%0d exp=2/1", bus.o_remaining, bus.o_elapsed); end
    bus.i_timer_mode = 1'b0;
    step(1);
    bus.i_timer_mode = 1'b1;
    tests_run++; if (dut_state !== S_IDLE || bus.o_remaining !== 5'd0 || bus.o_elapsed !== 5'd0 || bus.o_running !== 1'b0) begin fails++; $display("FAIL mode_drop got st=%0d rem=%0d el=%0d run=%b exp 0/0/0/0", dut_state, bus.o_remaining, bus.o_elapsed, bus.o_running); end
    tests_run++; if (exp_cnt !== 0) begin fails++; $display("FAIL zero_mode_pulses got=%0d exp=0", exp_cnt); end
    exp_cnt = 0;
  endtask

  task automatic test_reset_priority();
    do_load(5'd3);
    step(5);
    rst             = 1'b1;
    bus.i_load      = 1'b1;
    bus.i_timeState = 5'd7;
    step(1);
    rst        = 1'b0;
    bus.i_load = 1'b0;
    tests_run++; if (dut_state !== S_IDLE || bus.o_remaining !== 5'd0 || bus.o_elapsed !== 5'd0) begin fails++; $display("FAIL rstprio_counts got st=%0d rem=%0d el=%0d exp 0/0/0", dut_state, bus.o_remaining, bus.o_elapsed); end
    tests_run++; if ({bus.o_running, bus.o_done, bus.o_expired} !== 3'b000) begin fails++; $display("FAIL rstprio_flags got=%b exp=000", {bus.o_running, bus.o_done, bus.o_expired}); end
    exp_cnt = 0;
  endtask

  task automatic test_back_to_back();
    bus.i_pause = 1'b1;
    step(2);
    tests_run++; if (dut_state !== S_IDLE) begin fails++; $display("FAIL b2b_pause_idle got=%0d exp=0", dut_state); end
    do_load(5'd2);
    tests_run++; if (dut_state !== S_RUN || bus.o_remaining !== 5'd2) begin fails++; $display("FAIL b2b_load_over_pause got st=%0d rem=%0d exp 1/2", dut_state, bus.o_remaining); end
    step(1);
    tests_run++; if (dut_state !== S_PAUSE) begin fails++; $display("FAIL b2b_then_pause got=%0d exp=2", dut_state); end
    bus.i_pause = 1'b0;
    step(7);
    tests_run++; if (bus.o_remaining !== 5'd1 || bus.o_expired !== 1'b0) begin fails++; $display("FAIL b2b_pre got rem=%0d exp=%b exp 1/0", bus.o_remaining, bus.o_expired); end
    step(1);
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_expired !== 1'b1) begin fails++; $display("FAIL b2b_done got done=%b exp=%b exp 1/1", bus.o_done, bus.o_expired); end
    do_load(5'd31);
    tests_run++; if (bus.o_remaining !== 5'd31 || bus.o_done !== 1'b0 || bus.o_running !== 1'b1) begin fails++; $display("FAIL b2b_reload_from_done got rem=%0d done=%b run=%b exp 31/0/1", bus.o_remaining, bus.o_done, bus.o_running); end
    tests_run++; if (exp_cnt !== 1) begin fails++; $display("FAIL b2b_pulses got=%0d exp=1", exp_cnt); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_off_button();
    test_reload();
    test_zero_load_and_mode();
    test_reset_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
